// File: rtl/bist_controller.sv
// Logic-BIST session sequencer: seed LFSR, apply N_PATTERNS, flush the CUT into the MISR, compare signature.
// Optional BIST_SIG_CAPTURE_EN adds sig_captured, holding the last checked MISR signature for diagnosis.
module bist_controller #(
  parameter int               N_PATTERNS   = 1000,
  parameter int               CNT_W        = 16,
  parameter int               FLUSH_CYCLES = 2,
  parameter int               SIG_W        = 32,
  parameter logic [SIG_W-1:0] GOLDEN_SIG   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] signature,
  output logic             lfsr_reset,
  output logic             lfsr_enable,
  output logic             misr_clear,
  output logic             misr_enable,
  output logic             test_mode,
  output logic             busy,
  output logic             done,
  output logic             pass,
`ifdef BIST_SIG_CAPTURE_EN
  output logic [SIG_W-1:0] sig_captured,
`endif
  output logic [CNT_W-1:0] pattern_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_RUN, S_FLUSH, S_CHECK, S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] N_LAST  = CNT_W'(N_PATTERNS);
  localparam logic [CNT_W-1:0] F_LAST  = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             pass_q, pass_d;
  logic             lfsr_reset_q, lfsr_enable_q, misr_clear_q, misr_enable_q;
  logic             test_mode_q, busy_q, done_q;
`ifdef BIST_SIG_CAPTURE_EN
  logic [SIG_W-1:0] sig_q, sig_d;
`endif

  // cnt_q numbers the pattern applied in the current RUN cycle, so it reads N_PATTERNS on the last one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    pass_d  = pass_q;
`ifdef BIST_SIG_CAPTURE_EN
    sig_d   = sig_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_INIT;
          cnt_d   = '0;
          pass_d  = 1'b0;
`ifdef BIST_SIG_CAPTURE_EN
          sig_d   = '0;
`endif
        end
      end
      S_INIT: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else begin
          state_d = S_RUN;
          cnt_d   = CNT_ONE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else if (cnt_q == N_LAST) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_FLUSH;
            flush_d = CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_FLUSH: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else if (flush_q == F_LAST) begin
          state_d = S_CHECK;
        end else begin
          flush_d = flush_q + CNT_ONE;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else begin
          state_d = S_DONE;
          pass_d  = (signature == GOLDEN_SIG);
`ifdef BIST_SIG_CAPTURE_EN
          sig_d   = signature;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      flush_q       <= '0;
      pass_q        <= 1'b0;
      lfsr_reset_q  <= 1'b0;
      lfsr_enable_q <= 1'b0;
      misr_clear_q  <= 1'b0;
      misr_enable_q <= 1'b0;
      test_mode_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef BIST_SIG_CAPTURE_EN
      sig_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      flush_q       <= flush_d;
      pass_q        <= pass_d;
      lfsr_reset_q  <= (state_d == S_INIT);
      misr_clear_q  <= (state_d == S_INIT);
      lfsr_enable_q <= (state_d == S_RUN);
      misr_enable_q <= (state_d == S_RUN) || (state_d == S_FLUSH);
      test_mode_q   <= (state_d == S_INIT) || (state_d == S_RUN) ||
                       (state_d == S_FLUSH) || (state_d == S_CHECK);
      busy_q        <= (state_d == S_INIT) || (state_d == S_RUN) ||
                       (state_d == S_FLUSH) || (state_d == S_CHECK);
      done_q        <= (state_d == S_DONE);
`ifdef BIST_SIG_CAPTURE_EN
      sig_q         <= sig_d;
`endif
    end
  end

  assign lfsr_reset    = lfsr_reset_q;
  assign lfsr_enable   = lfsr_enable_q;
  assign misr_clear    = misr_clear_q;
  assign misr_enable   = misr_enable_q;
  assign test_mode     = test_mode_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign pattern_count = cnt_q;
`ifdef BIST_SIG_CAPTURE_EN
  assign sig_captured  = sig_q;
`endif

endmodule
